// File: rtl/neosd_dat_buf.sv
// ---------------------------------------------------------------------------
// neosd_dat_buf
//
// Data-path front-end of the SD host. CPU word accesses on a Wishbone slave
// port are decoupled from the SD data FSM through a FIFO. DIR selects which
// side fills the FIFO and which side drains it:
//   DIR=0 (card-to-host): the data FSM pushes words and the CPU pops them
//                         with DATA reads.
//   DIR=1 (host-to-card): the CPU pushes words with DATA writes and the data
//                         FSM pops the head.
// The block also counts the blocks of a multi-block transfer, drives the
// last-block indication, and owns the data-path flags, masks and interrupt.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   wb_adr_i .. wb_cyc_i   Wishbone slave request (only adr[4:2] decoded)
//   wb_ack_o, wb_dat_o     registered acknowledge / read data
//   fsm_dat_i/valid_i      card-to-host word from the data FSM
//   fsm_ready_o            buffer accepts that word (DIR=0 and not full)
//   fsm_dat_o/valid_o      host-to-card head word for the data FSM
//   fsm_ready_i            data FSM consumes the head
//   blk_done_i, crc_ok_i   block-finished pulse with its CRC status
//   last_block_o           block counter equals 1
//   irq_o                  level interrupt, OR of enabled flags
//
// Register map (adr[4:2])
//   0 CTRL   [0] DIR rw, [1] FLUSH wo, [12:8] MASK rw, [20:16] FLAGS,
//            [31:24] fill count ro
//            flag/mask bit order: LEVEL, XFER_DONE, CRCERR, OVR, UNDR
//   1 BLKCNT block counter, CNT_W bits
//   2 DATA   FIFO push (write) / pop (read)
//   3 THRESH [7:0] LEVEL threshold
// ---------------------------------------------------------------------------
module neosd_dat_buf #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] fsm_dat_i,
    input  logic        fsm_valid_i,
    output logic        fsm_ready_o,
    output logic [31:0] fsm_dat_o,
    output logic        fsm_valid_o,
    input  logic        fsm_ready_i,
    input  logic        blk_done_i,
    input  logic        crc_ok_i,
    output logic        last_block_o,
    output logic        irq_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;

    localparam logic [FILL_W-1:0] DEPTH_C    = FILL_W'(FIFO_DEPTH);
    localparam logic [7:0]        THRESH_RST = 8'(FIFO_DEPTH / 2);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_BLKCNT = 3'd1;
    localparam logic [2:0] REG_DATA   = 3'd2;
    localparam logic [2:0] REG_THRESH = 3'd3;

    // Sticky flag positions inside sticky_q (FLAGS[4:1] in the CTRL view;
    // FLAGS[0] is the combinational LEVEL bit).
    localparam int F_XFER = 0;
    localparam int F_CRC  = 1;
    localparam int F_OVR  = 2;
    localparam int F_UNDR = 3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [FILL_W-1:0] count_q,   count_d;
    logic              dir_q,     dir_d;
    logic [4:0]        mask_q,    mask_d;
    logic [3:0]        sticky_q,  sticky_d;
    logic [CNT_W-1:0]  blkcnt_q,  blkcnt_d;
    logic [7:0]        thresh_q,  thresh_d;
    logic              ack_q,     ack_d;
    logic [31:0]       rdat_q,    rdat_d;
    logic              irq_q,     irq_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       bus_req;
    logic       bus_acc;
    logic       bus_wr;
    logic       bus_rd;
    logic [2:0] reg_sel;

    assign bus_req = wb_stb_i & wb_cyc_i;
    // A request still held high while its ack is out is the same request,
    // so it must not trigger a second push/pop.
    assign bus_acc = bus_req & ~ack_q;
    assign bus_wr  = bus_acc & wb_we_i;
    assign bus_rd  = bus_acc & ~wb_we_i;
    assign reg_sel = wb_adr_i[4:2];

    logic ctrl_wr;
    logic blkcnt_wr;
    logic thresh_wr;

    assign ctrl_wr   = bus_wr && (reg_sel == REG_CTRL);
    assign blkcnt_wr = bus_wr && (reg_sel == REG_BLKCNT);
    assign thresh_wr = bus_wr && (reg_sel == REG_THRESH);

    // Only part of the address and data buses is decoded.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{wb_adr_i, wb_dat_i};

    // ------------------------------------------------------------------
    // FIFO status and handshakes
    // ------------------------------------------------------------------
    logic full;
    logic empty;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Both handshakes look at the current count only: a full FIFO refuses
    // a push even if a pop completes in the same cycle.
    assign fsm_ready_o = ~dir_q & ~full;
    assign fsm_valid_o = dir_q & ~empty;
    assign fsm_dat_o   = mem_q[rd_ptr_q];

    logic flush;
    logic bus_push_req, bus_push, ovr_set;
    logic bus_pop_req,  bus_pop,  undr_set;
    logic fsm_push, fsm_pop;
    logic push, pop;
    logic [31:0] push_data;

    assign flush = ctrl_wr & wb_dat_i[1];

    // DATA writes only push in host-to-card mode; in card-to-host mode
    // they are silently ignored.
    assign bus_push_req = bus_wr && (reg_sel == REG_DATA) && dir_q;
    assign bus_push     = bus_push_req & ~full;
    assign ovr_set      = bus_push_req & full;

    // DATA reads only pop in card-to-host mode.
    assign bus_pop_req = bus_rd && (reg_sel == REG_DATA) && !dir_q;
    assign bus_pop     = bus_pop_req & ~empty;
    assign undr_set    = bus_pop_req & empty;

    assign fsm_push = fsm_valid_i & fsm_ready_o;
    assign fsm_pop  = fsm_valid_o & fsm_ready_i;

    // DIR fixes the producer and the consumer, so at most one push source
    // and one pop source can be active.
    assign push      = bus_push | fsm_push;
    assign pop       = bus_pop | fsm_pop;
    assign push_data = dir_q ? wb_dat_i : fsm_dat_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Flush overrides any push or pop of the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + FILL_W'(1);
                2'b01:   count_d = count_q - FILL_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // ------------------------------------------------------------------
    // LEVEL: fill (card-to-host) or free space (host-to-card) against
    // THRESH. A threshold of 0 always satisfies the compare.
    // ------------------------------------------------------------------
    logic [8:0] fill_ext;
    logic [8:0] free_ext;
    logic [8:0] thr_ext;
    logic       level;

    assign fill_ext = 9'(count_q);
    assign free_ext = 9'(DEPTH_C - count_q);
    assign thr_ext  = {1'b0, thresh_q};
    assign level    = dir_q ? (free_ext >= thr_ext) : (fill_ext >= thr_ext);

    // ------------------------------------------------------------------
    // Block counter
    // ------------------------------------------------------------------
    logic xfer_set;
    logic crc_set;

    always_comb begin
        blkcnt_d = blkcnt_q;
        if (blkcnt_wr) begin
            // Software reload wins over a simultaneous block completion.
            blkcnt_d = wb_dat_i[CNT_W-1:0];
        end else if (blk_done_i && (blkcnt_q != '0)) begin
            blkcnt_d = blkcnt_q - CNT_W'(1);
        end
    end

    assign xfer_set     = blk_done_i && !blkcnt_wr && (blkcnt_q == CNT_W'(1));
    assign crc_set      = blk_done_i && !crc_ok_i;
    assign last_block_o = (blkcnt_q == CNT_W'(1));

    // ------------------------------------------------------------------
    // Sticky flags: hardware set dominates a write-1-to-clear.
    // ------------------------------------------------------------------
    logic [3:0] flag_set;
    logic [3:0] flag_clr;

    always_comb begin
        flag_set         = '0;
        flag_set[F_XFER] = xfer_set;
        flag_set[F_CRC]  = crc_set;
        flag_set[F_OVR]  = ovr_set;
        flag_set[F_UNDR] = undr_set;
    end

    assign flag_clr = ctrl_wr ? wb_dat_i[20:17] : 4'b0000;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sticky
        assign sticky_d[gi] = (sticky_q[gi] & ~flag_clr[gi]) | flag_set[gi];
    end

    logic [4:0] flags_all;
    assign flags_all = {sticky_q, level};

    // Interrupt reflects the registered flags and mask, so it follows any
    // flag or mask change by one cycle.
    assign irq_d = |(flags_all & mask_q);

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_comb begin
        dir_d    = dir_q;
        mask_d   = mask_q;
        thresh_d = thresh_q;
        if (ctrl_wr) begin
            dir_d  = wb_dat_i[0];
            mask_d = wb_dat_i[12:8];
        end
        if (thresh_wr) begin
            thresh_d = wb_dat_i[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Read mux; the data output is zero whenever no read is acknowledged.
    // ------------------------------------------------------------------
    always_comb begin
        rdat_d = '0;
        if (bus_rd) begin
            case (reg_sel)
                REG_CTRL:   rdat_d = {8'(count_q), 3'b000, flags_all, 3'b000,
                                      mask_q, 6'b000000, 1'b0, dir_q};
                REG_BLKCNT: rdat_d = 32'(blkcnt_q);
                REG_DATA:   rdat_d = bus_pop ? mem_q[rd_ptr_q] : 32'h0;
                REG_THRESH: rdat_d = {24'h0, thresh_q};
                default:    rdat_d = '0;
            endcase
        end
    end

    assign ack_d = bus_acc;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            mask_q   <= '0;
            sticky_q <= '0;
            blkcnt_q <= '0;
            thresh_q <= THRESH_RST;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            mask_q   <= mask_d;
            sticky_q <= sticky_d;
            blkcnt_q <= blkcnt_d;
            thresh_q <= thresh_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            irq_q    <= irq_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = rdat_q;
    assign irq_o    = irq_q;

endmodule

// File: doc/neosd_dat_buf.md
Name: neosd_dat_buf

Overview:
Parametrised Wishbone data-path front-end for the SD host. It decouples CPU word accesses from the SD data FSM through a FIFO of configurable depth, supporting both transfer directions. It counts blocks for multi-block transfers and drives the last-block indication to the data FSM. It owns the data-path flags, masks and interrupt, and sits between the bus switch and the data FSM, beside the command/control register block.

Parameters:
FIFO_DEPTH, 16, FIFO depth in 32-bit words; power of 2, 2..128.
CNT_W, 16, block-counter width, 1..24.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
wb_adr_i  in  32  byte address; only [4:2] decoded
wb_dat_i  in  32  write data
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_ack_o  out  1  acknowledge
wb_dat_o  out  32  read data
fsm_dat_i  in  32  word from data FSM (card-to-host)
fsm_valid_i  in  1  fsm_dat_i valid
fsm_ready_o  out  1  buffer accepts word (= DIR==0 && !full)
fsm_dat_o  out  32  word to data FSM (host-to-card) = FIFO head
fsm_valid_o  out  1  head valid (= DIR==1 && !empty)
fsm_ready_i  in  1  data FSM consumes head
blk_done_i  in  1  one-cycle pulse: block finished
crc_ok_i  in  1  CRC status, qualified by blk_done_i
last_block_o  out  1  current block is last (BLKCNT==1)
irq_o  out  1  interrupt, level

Behaviour:
- Reset, and every clock edge while rst_i=1: FIFO empty; all flags and masks 0; DIR=0; BLKCNT=0; THRESH=FIFO_DEPTH/2; wb_ack_o=0; wb_dat_o=0; irq_o=0. rst_i asserted mid-transfer discards FIFO contents.
- Bus access: a request is stb&cyc. wb_ack_o is asserted the cycle after each request, for exactly one cycle. No stall. wb_dat_o is registered; it is 0 in any cycle not acknowledging a read. Unmapped reads return 0.
- Register map (adr[4:2]):
  - 0 CTRL:
    - [0] DIR, rw: 0 = card-to-host, 1 = host-to-card.
    - [1] FLUSH, wo, reads 0.
    - [12:8] MASK, rw: LEVEL, XFER_DONE, CRCERR, OVR, UNDR.
    - [20:16] FLAGS, same order. LEVEL is ro; the others are sticky, write-1-to-clear.
    - [31:24] fill count, ro, zero-extended.
  - 1 BLKCNT: rw, CNT_W bits, upper bits read 0.
  - 2 DATA.
  - 3 THRESH: [7:0] rw.
- DATA write with DIR=1: push. If full, the word is dropped and OVR is set. DATA write with DIR=0: ignored, no flag.
- DATA read with DIR=0: pop; the head word is returned. If empty, returns 0, sets UNDR, pointers unchanged. DATA read with DIR=1: returns 0, no pop, no flag.
- FSM push: fsm_valid_i && fsm_ready_o. FSM pop: fsm_valid_o && fsm_ready_i.
- Push and pop in the same cycle: count unchanged, both complete. fsm_ready_o is derived from the current count only, so a full FIFO refuses a push even if a bus pop occurs in the same cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- FLUSH=1: pointers and count reset at the end of that cycle. Flush wins over any simultaneous push or pop. Flags are not touched.
- Changing DIR does not flush; software flushes before reversing.
- LEVEL (combinational from count):
  - DIR=0: count >= THRESH.
  - DIR=1: (FIFO_DEPTH - count) >= THRESH.
  - THRESH=0: LEVEL is always 1.
- Block counter, on blk_done_i:
  - BLKCNT != 0: decrement. Transition 1 -> 0 sets XFER_DONE. crc_ok_i=0 sets CRCERR.
  - BLKCNT == 0: saturates at 0, no XFER_DONE; CRCERR still updated.
- last_block_o = (BLKCNT == 1), combinational.
- Bus write to BLKCNT coinciding with blk_done_i: the written value wins and no XFER_DONE is raised.
- Flag set/clear priority: hardware set in the same cycle as a W1C clear leaves the flag set.
- irq_o = OR over (FLAGS & MASK), registered, one cycle after the flag/mask change.

Test Plan:
- Card-to-host fill: DIR=0, THRESH=4, push 0x11..0x14 via FSM -> LEVEL=1 after the 4th push; 4 DATA reads return 0x11..0x14 in order, each with a one-cycle ack; count reads 0.
- Full/overflow: DIR=1, depth 16, write 17 words -> 17th dropped, OVR=1, fill=16, fsm_valid_o=1; FSM drains 16 words in order with pointer wrap; a 5th DATA read of an empty FIFO in DIR=0 returns 0 and sets UNDR.
- Multi-block: BLKCNT=3, pulse blk_done_i three times with crc_ok_i=1,0,1 -> last_block_o high after the 2nd pulse; XFER_DONE set on the 3rd; CRCERR=1; a 4th pulse keeps BLKCNT=0.
- IRQ/W1C: MASK=XFER_DONE only, complete a transfer -> irq_o=1 one cycle after the flag; writing 1 to bit17 clears it; a simultaneous set and clear keeps the flag at 1.
- Flush race: DIR=0, FIFO holding 5 words, FLUSH in the same cycle as an FSM push -> count=0 next cycle; the pushed word is lost.
- Reset mid-transfer: rst_i=1 for one cycle with count=7, BLKCNT=2 -> count=0, BLKCNT=0, THRESH=8, irq_o=0, wb_ack_o=0.
